// File: rtl/rtc_captura_datos.sv
// -----------------------------------------------------------------------------
// rtc_captura_datos
//
// Captures the bytes that the RTC read-cycle controller pulls off the AD bus
// into a nine-field shadow bank. The bytes are indexed by field position:
//   0 seg, 1 min, 2 hora, 3 dia, 4 mes, 5 anio, 6 tseg, 7 tmin, 8 thora.
// When the controller signals the end of the read, all nine fields are
// committed to the display bank in one step. The VGA text path therefore
// never sees digits from two different reads.
//
// Optional feature macro: RTC_BCD_CHECK_EN
//   defined     : each captured byte is range-checked as packed BCD.
//                 err_campo holds the per-field result, and any flagged field
//                 blocks the commit.
//   not defined : every byte is accepted, err_campo is tied to 0, and a
//                 commit only needs all nine fields captured.
//
// Parameters
//   TIMEOUT_CYC : clk cycles allowed from the first capture to fin_lectura
//   ERR_W       : width of the saturating rejected-cycle counter
//
// Ports
//   clk          in   system clock, all logic on posedge
//   reset        in   asynchronous active-low reset (0 = reset)
//   dato_in      in   [7:0]  byte read from the RTC
//   posicion     in   [3:0]  field index 0..8; 9..15 are ignored
//   dato_valido  in   read-data strobe; a capture happens on its rising edge
//   fin_lectura  in   pulse: controller finished the read cycle
//   datos_rtc    out  [71:0] committed bank, field k at [8k+7:8k]
//   nuevo        out  one-cycle pulse when datos_rtc is updated
//   valido       out  high once at least one commit has succeeded
//   err_campo    out  [8:0]  per-field range-error flags
//   cuenta_err   out  [ERR_W-1:0] rejected/aborted cycles, saturating
// -----------------------------------------------------------------------------
module rtc_captura_datos #(
   parameter int TIMEOUT_CYC = 4096,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       dato_in,
   input  logic [3:0]       posicion,
   input  logic             dato_valido,
   input  logic             fin_lectura,
   output logic [71:0]      datos_rtc,
   output logic             nuevo,
   output logic             valido,
   output logic [8:0]       err_campo,
   output logic [ERR_W-1:0] cuenta_err
);

   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_FIN = TMR_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, CAPTURA, COMMIT} estado_t;

   estado_t          estado;
   logic             strobe_q;
   logic [71:0]      shadow;
   logic [8:0]       mask;
   logic [TMR_W-1:0] timer;
   logic [8:0]       cap_sel;
   logic             captura;
   logic             campos_ok;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // One-hot field select for a capture: only on the rising edge of the
   // strobe, so a strobe held for several cycles captures once. Positions
   // 9..15 select nothing and leave the FSM untouched.
   always_comb begin
      cap_sel = '0;
      for (int k = 0; k < 9; k++)
         cap_sel[k] = dato_valido && !strobe_q && (posicion == 4'(k));
   end

   assign captura = |cap_sel;

`ifdef RTC_BCD_CHECK_EN
   // Packed-BCD range check. Both nibbles must be decimal digits.
   // Comparing the raw bytes is then the same as comparing the decimal values.
   function automatic logic campo_valido(input logic [3:0] pos, input logic [7:0] b);
      logic [7:0] lim_lo;
      logic [7:0] lim_hi;
      lim_lo = 8'h00;
      lim_hi = 8'h99;
      case (pos)
         4'd0, 4'd1, 4'd6, 4'd7: lim_hi = 8'h59;
         4'd2, 4'd8:             lim_hi = 8'h23;
         4'd3: begin
            lim_lo = 8'h01;
            lim_hi = 8'h31;
         end
         4'd4: begin
            lim_lo = 8'h01;
            lim_hi = 8'h12;
         end
         default:                lim_hi = 8'h99;
      endcase
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b >= lim_lo) && (b <= lim_hi);
   endfunction

   logic [8:0] err_q;

   // Flags are only rewritten when their own field is captured again.
   // After a rejected cycle they therefore still show which fields were bad.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= '0;
      end else begin
         for (int k = 0; k < 9; k++)
            if (cap_sel[k]) err_q[k] <= !campo_valido(4'(k), dato_in);
      end
   end

   assign err_campo = err_q;
   assign campos_ok = (err_q == 9'd0);
`else
   assign err_campo = 9'd0;
   assign campos_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado     <= IDLE;
         strobe_q   <= 1'b0;
         shadow     <= '0;
         mask       <= '0;
         timer      <= '0;
         datos_rtc  <= '0;
         nuevo      <= 1'b0;
         valido     <= 1'b0;
         cuenta_err <= '0;
      end else begin
         strobe_q <= dato_valido;
         nuevo    <= 1'b0;

         for (int k = 0; k < 9; k++)
            if (cap_sel[k]) shadow[8*k +: 8] <= dato_in;

         case (estado)
            IDLE: begin
               if (captura) begin
                  estado <= CAPTURA;
                  mask   <= cap_sel;
                  timer  <= '0;
               end
            end

            CAPTURA: begin
               // A capture that coincides with fin_lectura lands in the mask.
               // The COMMIT check sees it.
               mask  <= mask | cap_sel;
               timer <= timer + 1'b1;
               if (fin_lectura) begin
                  estado <= COMMIT;
               end else if (timer == TMR_FIN) begin
                  estado     <= IDLE;
                  mask       <= '0;
                  timer      <= '0;
                  cuenta_err <= sat_inc(cuenta_err);
               end
            end

            COMMIT: begin
               if ((mask == 9'h1FF) && campos_ok) begin
                  datos_rtc <= shadow;
                  nuevo     <= 1'b1;
                  valido    <= 1'b1;
               end else begin
                  cuenta_err <= sat_inc(cuenta_err);
               end
               // A capture arriving now starts the next cycle on a clean mask.
               mask   <= cap_sel;
               timer  <= '0;
               estado <= captura ? CAPTURA : IDLE;
            end

            default: begin
               estado <= IDLE;
               mask   <= '0;
               timer  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_captura_datos.sv
module tb_rtc_captura_datos;

   localparam int TO = 64;
   localparam int EW = 6;

`ifdef RTC_BCD_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic [7:0]    dato_in;
   logic [3:0]    posicion;
   logic          dato_valido;
   logic          fin_lectura;
   logic [71:0]   datos_rtc;
   logic          nuevo;
   logic          valido;
   logic [8:0]    err_campo;
   logic [EW-1:0] cuenta_err;

   rtc_captura_datos #(
      .TIMEOUT_CYC(TO),
      .ERR_W      (EW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .dato_in    (dato_in),
      .posicion   (posicion),
      .dato_valido(dato_valido),
      .fin_lectura(fin_lectura),
      .datos_rtc  (datos_rtc),
      .nuevo      (nuevo),
      .valido     (valido),
      .err_campo  (err_campo),
      .cuenta_err (cuenta_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int          total = 0;
   int          bad   = 0;
   logic [71:0] exp_datos;
   logic        exp_valido;
   int          exp_cnt;
   logic [8:0]  exp_err;
   logic        nuevo_seen;

   typedef struct {
      logic [71:0] bytes;
      logic [8:0]  capmask;
      logic [8:0]  exp_err;
      logic        exp_ok;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void field_range(input int pos, output int lo, output int hi);
      case (pos)
         0, 1, 6, 7: begin lo = 0; hi = 59; end
         2, 8:       begin lo = 0; hi = 23; end
         3:          begin lo = 1; hi = 31; end
         4:          begin lo = 1; hi = 12; end
         default:    begin lo = 0; hi = 99; end
      endcase
   endfunction

   function automatic bit bcd_valid(input int pos, input logic [7:0] b);
      int lo, hi, d;
      if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 1'b0;
      d = int'(b[7:4]) * 10 + int'(b[3:0]);
      field_range(pos, lo, hi);
      return (d >= lo) && (d <= hi);
   endfunction

   function automatic logic [7:0] rand_byte(input int pos);
      int lo, hi, d;
      field_range(pos, lo, hi);
      d = int'($urandom_range(hi, lo));
      return {4'(d / 10), 4'(d % 10)};
   endfunction

   function automatic int sat(input int v);
      return (v < (2**EW - 1)) ? v + 1 : v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      nuevo_seen = nuevo_seen | nuevo;
   endtask

   task automatic strobe(input logic [3:0] pos, input logic [7:0] val, input int len);
      posicion    = pos;
      dato_in     = val;
      dato_valido = 1'b1;
      repeat (len) step();
      dato_valido = 1'b0;
      step();
   endtask

   // kind: 0 = rejected, 1 = committed, 2 = no cycle in progress
   task automatic finish(input string tag, input int kind, input logic [71:0] newd);
      logic [71:0] old_d;
      old_d = exp_datos;
      if (kind == 1) begin
         exp_datos  = newd;
         exp_valido = 1'b1;
      end else if (kind == 0) begin
         exp_cnt = sat(exp_cnt);
      end
      chk({tag, " stray nuevo"}, 72'(nuevo_seen), 72'(0));
      fin_lectura = 1'b1;
      step();
      fin_lectura = 1'b0;
      chk({tag, " nuevo@fin"}, 72'(nuevo), 72'(0));
      chk({tag, " datos@fin"}, datos_rtc, old_d);
      step();
      chk({tag, " nuevo"}, 72'(nuevo), 72'(kind == 1));
      chk({tag, " datos"}, datos_rtc, exp_datos);
      chk({tag, " valido"}, 72'(valido), 72'(exp_valido));
      chk({tag, " cuenta_err"}, 72'(cuenta_err), 72'(exp_cnt));
      chk({tag, " err_campo"}, 72'(err_campo), 72'(exp_err));
      step();
      chk({tag, " nuevo pulse end"}, 72'(nuevo), 72'(0));
      nuevo_seen = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " datos"}, datos_rtc, 72'(0));
      chk({tag, " nuevo"}, 72'(nuevo), 72'(0));
      chk({tag, " valido"}, 72'(valido), 72'(0));
      chk({tag, " err_campo"}, 72'(err_campo), 72'(0));
      chk({tag, " cuenta_err"}, 72'(cuenta_err), 72'(0));
   endtask

   initial begin
      int kind;

      tbl[0] = '{72'h01_05_10_24_06_15_12_30_45, 9'h1FF, 9'b000000000, 1'b1};
      tbl[1] = '{72'h01_05_10_24_06_15_25_30_45, 9'h1FF, 9'b000000100, 1'b0};
      tbl[2] = '{72'h01_05_10_24_06_15_12_30_45, 9'h03F, 9'b000000000, 1'b0};
      tbl[3] = '{72'h01_05_10_24_06_15_12_30_45, 9'h1C0, 9'b000000000, 1'b0};
      tbl[4] = '{72'h23_59_59_99_12_31_23_59_59, 9'h1FF, 9'b000000000, 1'b1};
      tbl[5] = '{72'h00_00_00_00_01_01_00_00_00, 9'h1FF, 9'b000000000, 1'b1};
      tbl[6] = '{72'h24_60_10_99_12_00_23_5A_59, 9'h1FF, 9'b110001010, 1'b0};
      tbl[7] = '{72'h00_00_00_A0_13_32_24_00_60, 9'h1FF, 9'b000111101, 1'b0};
      tbl[8] = '{72'h12_34_56_78_09_28_19_07_33, 9'h1FF, 9'b000000000, 1'b1};

      reset       = 1'b0;
      dato_in     = 8'h00;
      posicion    = 4'd0;
      dato_valido = 1'b0;
      fin_lectura = 1'b0;
      exp_datos   = '0;
      exp_valido  = 1'b0;
      exp_cnt     = 0;
      exp_err     = '0;
      nuevo_seen  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      reset = 1'b1;
      step();

      // table-driven read cycles
      for (int i = 0; i < 9; i++) begin
         for (int k = 0; k < 9; k++)
            if (tbl[i].capmask[k]) strobe(4'(k), tbl[i].bytes[8*k +: 8], 1);
         exp_err = CHK ? tbl[i].exp_err : 9'd0;
         kind = ((tbl[i].capmask == 9'h1FF) && (!CHK || tbl[i].exp_ok)) ? 1 : 0;
         finish($sformatf("vec%0d", i), kind, tbl[i].bytes);
         if (i == 0) chk("vec0 literal", datos_rtc, 72'h01_05_10_24_06_15_12_30_45);
      end

      // timeout: one capture, no fin
      strobe(4'd0, 8'h11, 1);
      repeat (TO - 2) step();
      chk("timeout early cuenta_err", 72'(cuenta_err), 72'(exp_cnt));
      step();
      exp_cnt = sat(exp_cnt);
      chk("timeout cuenta_err", 72'(cuenta_err), 72'(exp_cnt));
      chk("timeout datos", datos_rtc, exp_datos);
      for (int k = 0; k < 9; k++) strobe(4'(k), tbl[4].bytes[8*k +: 8], 1);
      finish("after timeout", 1, tbl[4].bytes);

      // ignored positions while idle must not start a cycle
      strobe(4'd9, 8'h77, 1);
      strobe(4'd15, 8'h66, 2);
      repeat (TO + 2) step();
      chk("ignored pos idle cuenta_err", 72'(cuenta_err), 72'(exp_cnt));

      // strobe held 5 cycles: one capture only
      posicion    = 4'd3;
      dato_in     = 8'h15;
      dato_valido = 1'b1;
      step();
      dato_in = 8'h45;
      repeat (4) step();
      dato_valido = 1'b0;
      step();
      for (int k = 0; k < 9; k++)
         if (k != 3) strobe(4'(k), tbl[0].bytes[8*k +: 8], 2);
      finish("held strobe", 1, tbl[0].bytes);

      // ignored positions inside a cycle
      for (int k = 0; k < 9; k++) strobe(4'(k), tbl[4].bytes[8*k +: 8], 1);
      strobe(4'd9, 8'h77, 1);
      strobe(4'd15, 8'h66, 1);
      finish("ignored pos", 1, tbl[4].bytes);

      // last capture together with fin_lectura
      for (int k = 0; k < 8; k++) strobe(4'(k), tbl[5].bytes[8*k +: 8], 1);
      posicion    = 4'd8;
      dato_in     = tbl[5].bytes[71:64];
      dato_valido = 1'b1;
      fin_lectura = 1'b1;
      step();
      dato_valido = 1'b0;
      fin_lectura = 1'b0;
      chk("simul nuevo@fin", 72'(nuevo), 72'(0));
      step();
      chk("simul nuevo", 72'(nuevo), 72'(1));
      chk("simul datos", datos_rtc, tbl[5].bytes);
      step();
      chk("simul nuevo end", 72'(nuevo), 72'(0));
      exp_datos  = tbl[5].bytes;
      nuevo_seen = 1'b0;

      // capture during COMMIT opens the next cycle
      for (int k = 0; k < 9; k++) strobe(4'(k), tbl[8].bytes[8*k +: 8], 1);
      fin_lectura = 1'b1;
      step();
      fin_lectura = 1'b0;
      posicion    = 4'd0;
      dato_in     = tbl[0].bytes[7:0];
      dato_valido = 1'b1;
      step();
      chk("commit-cap nuevo", 72'(nuevo), 72'(1));
      chk("commit-cap datos", datos_rtc, tbl[8].bytes);
      dato_valido = 1'b0;
      step();
      exp_datos  = tbl[8].bytes;
      nuevo_seen = 1'b0;
      for (int k = 1; k < 9; k++) strobe(4'(k), tbl[0].bytes[8*k +: 8], 1);
      finish("commit-cap next", 1, tbl[0].bytes);

      // asynchronous reset in the middle of a cycle
      for (int k = 0; k < 4; k++) strobe(4'(k), tbl[4].bytes[8*k +: 8], 1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk_reset_vals("async reset");
      step();
      reset = 1'b1;
      step();
      exp_datos  = '0;
      exp_valido = 1'b0;
      exp_cnt    = 0;
      exp_err    = '0;
      nuevo_seen = 1'b0;
      for (int k = 4; k < 9; k++) strobe(4'(k), tbl[4].bytes[8*k +: 8], 1);
      finish("post reset partial", 0, '0);

      // randomized read cycles against the transaction model
      for (int t = 0; t < 30; t++) begin
         int          q[$];
         logic [8:0]  have;
         logic [71:0] sh;
         q = {};
         if ($urandom_range(9, 0) < 6) begin
            for (int k = 0; k < 9; k++) q.push_back(k);
            for (int i = 8; i > 0; i--) begin
               int j, tmp;
               j    = int'($urandom_range(i, 0));
               tmp  = q[i];
               q[i] = q[j];
               q[j] = tmp;
            end
            repeat ($urandom_range(2, 0))
               q.insert(int'($urandom_range(q.size(), 0)), int'($urandom_range(15, 0)));
         end else begin
            repeat ($urandom_range(8, 1)) q.push_back(int'($urandom_range(15, 0)));
         end
         have = '0;
         sh   = '0;
         foreach (q[i]) begin
            logic [7:0] v;
            v = ($urandom_range(4, 0) == 0) ? 8'($urandom) : rand_byte(q[i]);
            strobe(4'(q[i]), v, int'($urandom_range(3, 1)));
            if (q[i] <= 8) begin
               have[q[i]]       = 1'b1;
               sh[8*q[i] +: 8]  = v;
               exp_err[q[i]]    = CHK && !bcd_valid(q[i], v);
            end
         end
         if (have == 9'd0)                             kind = 2;
         else if (have == 9'h1FF && exp_err == 9'd0)   kind = 1;
         else                                          kind = 0;
         finish($sformatf("rnd%0d", t), kind, sh);
      end

      // saturation of the rejected-cycle counter
      for (int i = 0; i < 64; i++) begin
         strobe(4'd0, 8'h00, 1);
         exp_err[0] = 1'b0;
         finish("sat", 0, '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
